// File: rtl/gpio_seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package gpio_seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam int         DIGITS  = 8;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/gpio_seg_scan_if.sv
// Scanner signal bundle: GPIO segment bytes and enable in, display drive out.
interface gpio_seg_scan_if;
  logic       en;
  logic [7:0] seg_in_0;
  logic [7:0] seg_in_1;
  logic [7:0] seg_in_2;
  logic [7:0] seg_in_3;
  logic [7:0] seg_in_4;
  logic [7:0] seg_in_5;
  logic [7:0] seg_in_6;
  logic [7:0] seg_in_7;
  logic [7:0] seg_o;
  logic [7:0] an_o;
  logic       frame_start;

  modport master (
    output en, seg_in_0, seg_in_1, seg_in_2, seg_in_3,
           seg_in_4, seg_in_5, seg_in_6, seg_in_7,
    input  seg_o, an_o, frame_start
  );

  modport slave (
    input  en, seg_in_0, seg_in_1, seg_in_2, seg_in_3,
           seg_in_4, seg_in_5, seg_in_6, seg_in_7,
    output seg_o, an_o, frame_start
  );
endinterface

// File: rtl/gpio_seg_scan.sv
// Time-multiplexed 8-digit 7-seg driver with per-slot blanking and per-frame input snapshot.
// state | meaning
// IDLE  | scan disabled, display dark
// BLANK | slot start, all anodes off (anti-ghosting)
// SHOW  | current digit driven from the snapshot
module gpio_seg_scan
  import gpio_seg_scan_pkg::*;
#(
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input logic            clock,
  input logic            reset,
  gpio_seg_scan_if.slave bus
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);

  if (DIGIT_CYCLES < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_param_check
    $error("gpio_seg_scan: need 1 <= BLANK_CYCLES < DIGIT_CYCLES and DIGIT_CYCLES >= 2");
  end

  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [7:0]    snap   [DIGITS];
  logic [7:0]    seg_in [DIGITS];

  always_comb begin
    seg_in[0] = bus.seg_in_0;
    seg_in[1] = bus.seg_in_1;
    seg_in[2] = bus.seg_in_2;
    seg_in[3] = bus.seg_in_3;
    seg_in[4] = bus.seg_in_4;
    seg_in[5] = bus.seg_in_5;
    seg_in[6] = bus.seg_in_6;
    seg_in[7] = bus.seg_in_7;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      bus.an_o        <= AN_OFF;
      bus.seg_o       <= SEG_OFF;
      bus.frame_start <= 1'b0;
      for (int i = 0; i < DIGITS; i++) snap[i] <= SEG_OFF;
    end else if (!bus.en) begin
      // Snapshot is deliberately kept; re-enable takes a fresh one anyway.
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      bus.an_o        <= AN_OFF;
      bus.seg_o       <= SEG_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= 1'b0;
      case (state)
        IDLE: begin
          state           <= BLANK;
          idx             <= '0;
          cnt             <= '0;
          snap            <= seg_in;
          bus.frame_start <= 1'b1;
          bus.an_o        <= AN_OFF;
          bus.seg_o       <= SEG_OFF;
        end
        BLANK: begin
          cnt <= cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state     <= SHOW;
            bus.an_o  <= anode_sel(idx);
            bus.seg_o <= snap[idx];
          end
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            state     <= BLANK;
            cnt       <= '0;
            idx       <= idx + 3'd1;
            bus.an_o  <= AN_OFF;
            bus.seg_o <= SEG_OFF;
            if (idx == 3'd7) begin
              snap            <= seg_in;
              bus.frame_start <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.an_o  <= AN_OFF;
          bus.seg_o <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_seg_scan.sv
// Bench for gpio_seg_scan: two instances (4/1 and 2/1 timing) against a frame-position model.
module tb_gpio_seg_scan;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [7:0] seg_in [8];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_on      = 1'b0;

  always #5 clock = ~clock;

  gpio_seg_scan_if bus_a ();
  gpio_seg_scan_if bus_b ();

  assign bus_a.en = en;
  assign bus_b.en = en;
  assign bus_a.seg_in_0 = seg_in[0];  assign bus_b.seg_in_0 = seg_in[0];
  assign bus_a.seg_in_1 = seg_in[1];  assign bus_b.seg_in_1 = seg_in[1];
  assign bus_a.seg_in_2 = seg_in[2];  assign bus_b.seg_in_2 = seg_in[2];
  assign bus_a.seg_in_3 = seg_in[3];  assign bus_b.seg_in_3 = seg_in[3];
  assign bus_a.seg_in_4 = seg_in[4];  assign bus_b.seg_in_4 = seg_in[4];
  assign bus_a.seg_in_5 = seg_in[5];  assign bus_b.seg_in_5 = seg_in[5];
  assign bus_a.seg_in_6 = seg_in[6];  assign bus_b.seg_in_6 = seg_in[6];
  assign bus_a.seg_in_7 = seg_in[7];  assign bus_b.seg_in_7 = seg_in[7];

  gpio_seg_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  gpio_seg_scan #(.DIGIT_CYCLES(2), .BLANK_CYCLES(1)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  // Reference model: a running position within the frame plus a captured copy of the inputs.
  int         dcv [2] = '{4, 2};
  bit         m_act [2];
  int         m_p [2];
  bit         m_fs [2];
  logic [7:0] m_snap [2][8];

  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_act[m] = 1'b0; m_p[m] = 0; m_fs[m] = 1'b0;
        for (int i = 0; i < 8; i++) m_snap[m][i] = 8'hFF;
      end else if (!en) begin
        m_act[m] = 1'b0; m_p[m] = 0; m_fs[m] = 1'b0;
      end else if (!m_act[m]) begin
        m_act[m] = 1'b1; m_p[m] = 0; m_fs[m] = 1'b1;
        for (int i = 0; i < 8; i++) m_snap[m][i] = seg_in[i];
      end else begin
        m_p[m]  = (m_p[m] + 1) % (8 * dcv[m]);
        m_fs[m] = (m_p[m] == 0);
        if (m_p[m] == 0)
          for (int i = 0; i < 8; i++) m_snap[m][i] = seg_in[i];
      end
    end
  end

  function automatic logic [7:0] exp_an(int m);
    if (!m_act[m] || (m_p[m] % dcv[m]) < 1) return 8'hFF;
    return ~(8'b1 << (m_p[m] / dcv[m]));
  endfunction

  function automatic logic [7:0] exp_seg(int m);
    if (!m_act[m] || (m_p[m] % dcv[m]) < 1) return 8'hFF;
    return m_snap[m][m_p[m] / dcv[m]];
  endfunction

  // Per-cycle monitor: model agreement plus the one-anode / dark-when-off invariants.
  always @(posedge clock) begin
    #1;
    if (mon_on) begin
      vectors++;
      if (bus_a.an_o !== exp_an(0) || bus_a.seg_o !== exp_seg(0) || bus_a.frame_start !== m_fs[0]) begin
        miscompares++;
        $display("FAIL model_a t=%0t an=%h seg=%h fs=%b expected an=%h seg=%h fs=%b",
                 $time, bus_a.an_o, bus_a.seg_o, bus_a.frame_start, exp_an(0), exp_seg(0), m_fs[0]);
      end
      vectors++;
      if (bus_b.an_o !== exp_an(1) || bus_b.seg_o !== exp_seg(1) || bus_b.frame_start !== m_fs[1]) begin
        miscompares++;
        $display("FAIL model_b t=%0t an=%h seg=%h fs=%b expected an=%h seg=%h fs=%b",
                 $time, bus_b.an_o, bus_b.seg_o, bus_b.frame_start, exp_an(1), exp_seg(1), m_fs[1]);
      end
      vectors++;
      if ($countones(~bus_a.an_o) > 1 || (bus_a.an_o == 8'hFF && bus_a.seg_o != 8'hFF) ||
          $countones(~bus_b.an_o) > 1 || (bus_b.an_o == 8'hFF && bus_b.seg_o != 8'hFF)) begin
        miscompares++;
        $display("FAIL invariant t=%0t an_a=%h seg_a=%h an_b=%h seg_b=%h required <=1 anode low, dark when off",
                 $time, bus_a.an_o, bus_a.seg_o, bus_b.an_o, bus_b.seg_o);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until the A-model sits at frame position target.
  task automatic wait_pos(input int target);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_act[0] && m_p[0] == target) && n < 200);
    if (!(m_act[0] && m_p[0] == target)) begin
      miscompares++;
      $display("FAIL wait_pos timeout position=%0d required=%0d", m_p[0], target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0;
    for (int i = 0; i < 8; i++) seg_in[i] = 8'h10 + 8'(i);
    repeat (3) step();
    vectors++;
    if (bus_a.an_o !== 8'hFF || bus_a.seg_o !== 8'hFF || bus_a.frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a an=%h seg=%h fs=%b required FF/FF/0", bus_a.an_o, bus_a.seg_o, bus_a.frame_start);
    end
    vectors++;
    if (bus_b.an_o !== 8'hFF || bus_b.seg_o !== 8'hFF || bus_b.frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b an=%h seg=%h fs=%b required FF/FF/0", bus_b.an_o, bus_b.seg_o, bus_b.frame_start);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_scan();
    logic [7:0] e_an, e_seg;
    reset = 1'b0; en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      e_an  = ((k % 4) == 0) ? 8'hFF : ~(8'b1 << ((k / 4) % 8));
      e_seg = ((k % 4) == 0) ? 8'hFF : 8'h10 + 8'((k / 4) % 8);
      vectors++;
      if (bus_a.an_o !== e_an || bus_a.seg_o !== e_seg || bus_a.frame_start !== ((k % 32) == 0)) begin
        miscompares++;
        $display("FAIL scan k=%0d an=%h seg=%h fs=%b required an=%h seg=%h fs=%b",
                 k, bus_a.an_o, bus_a.seg_o, bus_a.frame_start, e_an, e_seg, (k % 32) == 0);
      end
    end
  endtask

  task automatic test_no_tear();
    wait_pos(1 * 4 + 1);
    seg_in[3] = 8'h55;
    wait_pos(3 * 4 + 1);
    vectors++;
    if (bus_a.an_o !== 8'hF7 || bus_a.seg_o !== 8'h13) begin
      miscompares++;
      $display("FAIL no_tear_old an=%h seg=%h required F7/13", bus_a.an_o, bus_a.seg_o);
    end
    wait_pos(3 * 4 + 1);
    vectors++;
    if (bus_a.an_o !== 8'hF7 || bus_a.seg_o !== 8'h55) begin
      miscompares++;
      $display("FAIL no_tear_new an=%h seg=%h required F7/55", bus_a.an_o, bus_a.seg_o);
    end
  endtask

  task automatic test_disable();
    wait_pos(5 * 4 + 2);
    en = 1'b0;
    step();
    vectors++;
    if (bus_a.an_o !== 8'hFF || bus_a.seg_o !== 8'hFF || bus_a.frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_dark an=%h seg=%h fs=%b required FF/FF/0", bus_a.an_o, bus_a.seg_o, bus_a.frame_start);
    end
    repeat (2) step();
    en = 1'b1;
    step();
    vectors++;
    if (bus_a.frame_start !== 1'b1 || bus_a.an_o !== 8'hFF) begin
      miscompares++;
      $display("FAIL reenable_start fs=%b an=%h required 1/FF", bus_a.frame_start, bus_a.an_o);
    end
    step();
    vectors++;
    if (bus_a.an_o !== 8'hFE || bus_a.seg_o !== 8'h10) begin
      miscompares++;
      $display("FAIL reenable_digit0 an=%h seg=%h required FE/10", bus_a.an_o, bus_a.seg_o);
    end
  endtask

  task automatic test_mid_reset();
    seg_in[0] = 8'hA5;
    wait_pos(6 * 4 + 1);
    reset = 1'b1;
    step();
    vectors++;
    if (bus_a.an_o !== 8'hFF || bus_a.seg_o !== 8'hFF || bus_a.frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset an=%h seg=%h fs=%b required FF/FF/0", bus_a.an_o, bus_a.seg_o, bus_a.frame_start);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (bus_a.frame_start !== 1'b1 || bus_a.an_o !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_restart fs=%b an=%h required 1/FF", bus_a.frame_start, bus_a.an_o);
    end
    step();
    vectors++;
    if (bus_a.an_o !== 8'hFE || bus_a.seg_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL reset_snapshot an=%h seg=%h required FE/A5", bus_a.an_o, bus_a.seg_o);
    end
  endtask

  task automatic test_short_slot();
    int n = 0;
    logic [7:0] e_an;
    while (bus_b.frame_start !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (bus_b.frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL short_slot_sync fs=%b required 1 within 40 cycles", bus_b.frame_start);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      e_an = ((k % 2) == 0) ? 8'hFF : ~(8'b1 << ((k / 2) % 8));
      vectors++;
      if (bus_b.an_o !== e_an || bus_b.frame_start !== (k == 16)) begin
        miscompares++;
        $display("FAIL short_slot k=%0d an=%h fs=%b required an=%h fs=%b",
                 k, bus_b.an_o, bus_b.frame_start, e_an, k == 16);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 1500; c++) begin
      step();
      r = int'($urandom_range(0, 999));
      if (r < 100) seg_in[$urandom_range(0, 7)] = 8'($urandom);
      reset = (r >= 990);
      if (r >= 960 && r < 980) en = ~en;
      else if (!en && r < 300) en = 1'b1;
    end
    reset = 1'b0; en = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_no_tear();
    test_disable();
    test_mid_reset();
    test_short_slot();
    test_random();
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
